cap_rd_node: RTL and testbench

Readout engine for the on-chip watcher capture buffer. After the trigger node has stopped, it reads the capture RAM in chronological order, unrolling the circular buffer from the stop point. It presents each sample on a valid/ready stream toward the configuration interface, which shifts it out over JTAG. It sits on the `cfg_clk` side of the capture RAM's read port.

---
 rtl/cap_rd_node.sv | 163 ++++++++++++++++
 tb/tb_cap_rd_node.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cap_rd_node.sv
// cap_rd_node: chronological readout of the watcher capture buffer.
// Once the trigger node has frozen the buffer, a start request latches
// the window (base address and word count). The circular buffer is then
// unrolled from the oldest sample onward, one word per RD/LAT/OUT round
// trip, onto a valid/ready stream.
// Optional feature macro: CAP_RD_HEADER_EN. When it is defined, a single
// header beat {overflow_flag, zero pad, count} precedes the samples.
module cap_rd_node #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              cfg_clk,
    input  logic              cfg_rst,
    input  logic              start,
    input  logic              abort,
    input  logic              stop_flag,
    input  logic              overflow_flag,
    input  logic [ADDR_W-1:0] stop_addr,
    input  logic [ADDR_W-1:0] trig_len,
    output logic              rd_ce,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [CNT_W-1:0]  ONE_C = 1;

`ifdef CAP_RD_HEADER_EN
    localparam int PAD_W = DATA_W - CNT_W - 1;
`endif

`ifdef CAP_RD_HEADER_EN
    typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_OUT, S_HDR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RD, S_LAT, S_OUT} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] trig_len_q;   // buffer depth-1, frozen at start
    logic [CNT_W-1:0]  remaining;    // words still to deliver, incl. current

    // Circular pointer advance: wraps to 0 after the last buffer slot.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] p,
                                                   input logic [ADDR_W-1:0] lim);
        return (p == lim) ? '0 : p + ONE_A;
    endfunction

    // Oldest sample: right after the stop point when the buffer has wrapped,
    // otherwise the start of the buffer.
    function automatic logic [ADDR_W-1:0] window_base(input logic              ovf,
                                                      input logic [ADDR_W-1:0] saddr,
                                                      input logic [ADDR_W-1:0] tlen);
        return ovf ? wrap_inc(saddr, tlen) : '0;
    endfunction

    // Number of valid samples; one extra bit so a full 2^ADDR_W buffer fits.
    function automatic logic [CNT_W-1:0] window_count(input logic              ovf,
                                                      input logic [ADDR_W-1:0] saddr,
                                                      input logic [ADDR_W-1:0] tlen);
        return ovf ? ({1'b0, tlen} + ONE_C) : ({1'b0, saddr} + ONE_C);
    endfunction

`ifdef CAP_RD_HEADER_EN
    // Header word: wrap flag in the MSB, sample count in the low bits.
    function automatic logic [DATA_W-1:0] header_word(input logic             ovf,
                                                      input logic [CNT_W-1:0] cnt);
        return {ovf, {PAD_W{1'b0}}, cnt};
    endfunction
`endif

    // Readout FSM with all outputs registered; abort overrides every state.
    always_ff @(posedge cfg_clk or posedge cfg_rst) begin
        if (cfg_rst) begin
            state      <= S_IDLE;
            trig_len_q <= '0;
            remaining  <= '0;
            rd_ce      <= 1'b0;
            rd_addr    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                rd_ce     <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && stop_flag) begin
                            trig_len_q <= trig_len;
                            rd_addr    <= window_base(overflow_flag, stop_addr, trig_len);
                            remaining  <= window_count(overflow_flag, stop_addr, trig_len);
                            busy       <= 1'b1;
`ifdef CAP_RD_HEADER_EN
                            state     <= S_HDR;
                            out_data  <= header_word(overflow_flag,
                                             window_count(overflow_flag, stop_addr, trig_len));
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
`else
                            state <= S_RD;
                            rd_ce <= 1'b1;
`endif
                        end
                    end
`ifdef CAP_RD_HEADER_EN
                    S_HDR: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            rd_ce     <= 1'b1;
                            state     <= S_RD;
                        end
                    end
`endif
                    S_RD: begin
                        // Read issued this cycle; RAM answers next cycle.
                        rd_ce <= 1'b0;
                        state <= S_LAT;
                    end
                    S_LAT: begin
                        out_data  <= rd_data;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == ONE_C);
                        state     <= S_OUT;
                    end
                    S_OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            remaining <= remaining - ONE_C;
                            rd_addr   <= wrap_inc(rd_addr, trig_len_q);
                            if (remaining == ONE_C) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_IDLE;
                            end else begin
                                rd_ce <= 1'b1;
                                state <= S_RD;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cap_rd_node.sv
// tb_cap_rd_node: randomized and directed readout transactions checked
// against an address-list model of the unrolled circular buffer.
module tb_cap_rd_node;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;

    logic              cfg_clk = 1'b0;
    logic              cfg_rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              stop_flag = 1'b0;
    logic              overflow_flag = 1'b0;
    logic [ADDR_W-1:0] stop_addr = '0;
    logic [ADDR_W-1:0] trig_len = '0;
    logic              rd_ce;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;

    cap_rd_node #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .cfg_clk      (cfg_clk),
        .cfg_rst      (cfg_rst),
        .start        (start),
        .abort        (abort),
        .stop_flag    (stop_flag),
        .overflow_flag(overflow_flag),
        .stop_addr    (stop_addr),
        .trig_len     (trig_len),
        .rd_ce        (rd_ce),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 cfg_clk = ~cfg_clk;

    // Capture RAM contents are a fixed function of the address.
    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return {a, ~a} ^ 32'h5A3C_96E1;
    endfunction

    // Synchronous RAM read port; garbage when not enabled.
    always @(posedge cfg_clk) begin
        rd_data <= rd_ce ? ram_word(rd_addr) : 32'($urandom);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_ce"}, rd_ce, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // One readout transaction. Called right after a falling edge.
    // stall_beat/abort_beat are 0-based sample indices, -1 for none.
    task automatic run_txn(input int tl, input int sa, input bit ovf, input int rdy_pct,
                           input int stall_beat, input int abort_beat);
        int cnt, base, cyc, ref_cyc, rd_idx, beat, hold_n, budget, tmp;
        bit hdr_pend, done_exp, fin, prev_v;
        int exp_a[$];
        logic [31:0] exp_d;
        logic        exp_l;
        logic [16:0] c17;
        if (ovf) begin
            cnt  = tl + 1;
            base = (sa == tl) ? 0 : sa + 1;
        end else begin
            cnt  = sa + 1;
            base = 0;
        end
        for (int k = 0; k < cnt; k++)
            exp_a.push_back(ovf ? (base + k) % (tl + 1) : k);
        c17 = cnt[16:0];
        trig_len      = tl[15:0];
        stop_addr     = sa[15:0];
        overflow_flag = ovf;
        stop_flag     = 1'b1;
        start         = 1'b1;
`ifdef CAP_RD_HEADER_EN
        hdr_pend = 1'b1;
`else
        hdr_pend = 1'b0;
`endif
        cyc = 0; ref_cyc = 0; rd_idx = 0; beat = 0; hold_n = 0;
        done_exp = 1'b0; fin = 1'b0; prev_v = 1'b0;
        budget = cnt * 60 + 40;
        while (!fin && cyc < budget) begin
            @(negedge cfg_clk);
            cyc++;
            if (cyc == 1) begin
                // Held inputs must be ignored for the rest of the transaction.
                start         = 1'b0;
                trig_len      = 16'($urandom);
                stop_addr     = 16'($urandom);
                overflow_flag = 1'($urandom);
                stop_flag     = 1'($urandom);
            end
            if (done_exp) begin
                chk("done_pulse", done, 1);
                chk("busy_end", busy, 0);
                chk("valid_end", out_valid, 0);
                chk("rdce_end", rd_ce, 0);
                fin = 1'b1;
            end else begin
                chk("busy", busy, 1);
                chk("no_done", done, 0);
                if (rd_ce) begin
                    chk("rd_lat", cyc - ref_cyc, 1);
                    chk("rd_in_range", rd_idx < cnt, 1);
                    if (rd_idx < cnt) chk("rd_addr", rd_addr, exp_a[rd_idx]);
                    chk("rd_while_valid", out_valid, 0);
                    rd_idx++;
                end
                if (out_valid) begin
                    if (!prev_v) chk("valid_lat", cyc - ref_cyc, hdr_pend ? 1 : 3);
                    exp_d = '0;
                    exp_l = 1'b0;
                    if (hdr_pend) begin
                        exp_d = {ovf, 14'b0, c17};
                    end else if (beat < cnt) begin
                        tmp   = exp_a[beat];
                        exp_d = ram_word(16'(tmp));
                        exp_l = (beat == cnt - 1);
                    end
                    chk("out_data", out_data, exp_d);
                    chk("out_last", out_last, exp_l);
                    if (!hdr_pend && beat == abort_beat) begin
                        abort     = 1'b1;
                        out_ready = 1'b0;
                        @(negedge cfg_clk);
                        abort = 1'b0;
                        chk("abort_busy", busy, 0);
                        chk("abort_valid", out_valid, 0);
                        chk("abort_rdce", rd_ce, 0);
                        chk("abort_done", done, 0);
                        repeat (3) begin
                            @(negedge cfg_clk);
                            chk("abort_nodone", done, 0);
                            chk("abort_idle", busy, 0);
                        end
                        fin = 1'b1;
                    end else begin
                        if (!hdr_pend && beat == stall_beat && hold_n < 5) begin
                            out_ready = 1'b0;
                            hold_n++;
                        end else begin
                            out_ready = ($urandom_range(99) < rdy_pct);
                        end
                        if (out_ready) begin
                            ref_cyc = cyc;
                            if (hdr_pend) hdr_pend = 1'b0;
                            else begin
                                if (beat == cnt - 1) done_exp = 1'b1;
                                beat++;
                            end
                        end
                    end
                end else begin
                    out_ready = 1'($urandom);
                end
                prev_v = out_valid;
            end
        end
        out_ready = 1'b0;
        abort     = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        if (done_exp && fin) begin
            @(negedge cfg_clk);
            chk("done_once", done, 0);
            chk("beats", beat, cnt);
            chk("reads", rd_idx, cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int tl, sa;
        // Reset state
        repeat (2) @(negedge cfg_clk);
        chk_idle_outputs("reset");
        cfg_rst = 1'b0;
        @(negedge cfg_clk);

        // Directed windows
        run_txn(7, 2, 1'b0, 100, -1, -1);
        run_txn(7, 5, 1'b1, 100, -1, -1);
        run_txn(7, 7, 1'b1, 100, -1, -1);
        run_txn(7, 3, 1'b1, 100, 1, -1);    // 5-cycle stall on beat 2
        run_txn(0, 0, 1'b1, 100, -1, -1);   // single-slot buffer
        run_txn(0, 0, 1'b0, 60, -1, -1);
        run_txn(16'hFFFF, 4, 1'b0, 100, -1, -1);
        run_txn(16'hFFFF, 16'hFFFE, 1'b0, 100, -1, 3);
        run_txn(7, 5, 1'b1, 100, -1, 2);    // abort on beat 3

        // start without stop_flag is ignored
        stop_flag = 1'b0;
        start     = 1'b1;
        @(negedge cfg_clk);
        start = 1'b0;
        repeat (5) begin
            chk("nostop_busy", busy, 0);
            chk("nostop_rdce", rd_ce, 0);
            chk("nostop_valid", out_valid, 0);
            @(negedge cfg_clk);
        end

        // Reset in the middle of a beat
        trig_len = 16'd7; stop_addr = 16'd5; overflow_flag = 1'b1; stop_flag = 1'b1;
        start = 1'b1;
        @(negedge cfg_clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge cfg_clk);
        chk("rst_pre_valid", out_valid, 1);
        #2 cfg_rst = 1'b1;
        #1 chk_idle_outputs("midrst");
        @(negedge cfg_clk);
        cfg_rst = 1'b0;
        repeat (3) begin
            @(negedge cfg_clk);
            chk("midrst_nodone", done, 0);
            chk("midrst_idle", busy, 0);
        end

        // Randomized windows with random backpressure
        for (int n = 0; n < 30; n++) begin
            tl = $urandom_range(15);
            sa = $urandom_range(tl);
            run_txn(tl, sa, 1'($urandom), $urandom_range(100, 30),
                    ($urandom_range(3) == 0) ? $urandom_range(tl) : -1,
                    ($urandom_range(7) == 0) ? $urandom_range(tl) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
